// File: rtl/blur_pkg.sv
// Shared types and kernel constants for the separable blur engine.
package blur_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, VPASS, HPASS, DONE} blur_state_e;

  // Binomial kernels, one 4-bit weight per nibble, tap 0 in the top nibble.
  localparam logic [11:0] KERNEL3 = {4'd1, 4'd2, 4'd1};
  localparam logic [19:0] KERNEL5 = {4'd1, 4'd4, 4'd6, 4'd4, 4'd1};

  function automatic logic [3:0] tap_weight(input int taps, input int idx);
    logic [3:0] w;
    w = 4'd0;
    if (taps == 3) begin
      case (idx)
        0:       w = KERNEL3[11:8];
        1:       w = KERNEL3[7:4];
        2:       w = KERNEL3[3:0];
        default: w = 4'd0;
      endcase
    end else begin
      case (idx)
        0:       w = KERNEL5[19:16];
        1:       w = KERNEL5[15:12];
        2:       w = KERNEL5[11:8];
        3:       w = KERNEL5[7:4];
        4:       w = KERNEL5[3:0];
        default: w = 4'd0;
      endcase
    end
    return w;
  endfunction

  // log2 of the kernel divisor (4 or 16)
  function automatic int tap_shift(input int taps);
    return (taps == 3) ? 2 : 4;
  endfunction

endpackage

// File: rtl/blur_tap_sum.sv
// Combinational weighted sum with round-half-up, or centre-tap pass-through in bypass.
module blur_tap_sum
  import blur_pkg::*;
#(
  parameter int PIX_BITS = 8,
  parameter int TAPS     = 5
) (
  input  logic                     blur,
  input  logic [TAPS*PIX_BITS-1:0] taps,
  output logic [PIX_BITS-1:0]      result
);

  localparam int ACC_W = PIX_BITS + 4;
  localparam int SHIFT = tap_shift(TAPS);
  localparam logic [ACC_W-1:0] HALF = ACC_W'(1 << (SHIFT - 1));

  logic [ACC_W-1:0] acc;

  // Weights sum to 16 at most, so the rounded sum always fits in ACC_W bits.
  always_comb begin
    acc = HALF;
    for (int j = 0; j < TAPS; j++) begin
      acc = acc + ACC_W'(taps[j*PIX_BITS +: PIX_BITS]) * ACC_W'(tap_weight(TAPS, j));
    end
  end

  assign result = blur ? PIX_BITS'(acc >> SHIFT) : taps[(TAPS/2)*PIX_BITS +: PIX_BITS];

endmodule

// File: rtl/sep_blur_engine.sv
// Separable column blur: vertical pass into a circular column history, then a
// horizontal pass across the history emitting one pixel per cycle.
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | capture in_col and mode
//   VPASS | one vertical result per row into history column wr_ptr
//   HPASS | one horizontal result per row, out_valid high
//   DONE  | one-cycle done pulse
module sep_blur_engine
  import blur_pkg::*;
#(
  parameter int PIX_BITS = 8,
  parameter int OUT_ROWS = 16,
  parameter int TAPS     = 5
) (
  input  logic                                  clk,
  input  logic                                  n_rst,
  input  logic                                  start,
  input  logic                                  mode,
  input  logic                                  flush,
  input  logic [(OUT_ROWS+TAPS-1)*PIX_BITS-1:0] in_col,
  output logic                                  busy,
  output logic                                  out_valid,
  output logic [$clog2(OUT_ROWS)-1:0]           out_row,
  output logic [PIX_BITS-1:0]                   out_pixel,
  output logic                                  done
);

  localparam int ROW_W  = $clog2(OUT_ROWS);
  localparam int PTR_W  = $clog2(TAPS);
  localparam int PW1    = PTR_W + 1;
  localparam int FILL_W = $clog2(TAPS + 1);
  localparam int COL_W  = (OUT_ROWS + TAPS - 1) * PIX_BITS;

  blur_state_e state, state_nxt;

  logic [ROW_W-1:0]         row_idx;
  logic [PTR_W-1:0]         wr_ptr;
  logic [FILL_W-1:0]        fill_cnt;
  logic [COL_W-1:0]         col_q;
  logic                     blur_q;
  logic [PIX_BITS-1:0]      hist [TAPS][OUT_ROWS];
  logic [TAPS*PIX_BITS-1:0] vtaps;
  logic [TAPS*PIX_BITS-1:0] htaps;
  logic [PIX_BITS-1:0]      vsum;
  logic [PIX_BITS-1:0]      hsum;
  logic                     last_row;
  logic                     window_ready;

  assign last_row = (row_idx == ROW_W'(OUT_ROWS - 1));
  // The history holds a full window once the column now in VPASS is written.
  assign window_ready = (fill_cnt >= FILL_W'(TAPS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = VPASS;
      VPASS:   if (last_row) state_nxt = window_ready ? HPASS : DONE;
      HPASS:   if (last_row) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      row_idx  <= '0;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      col_q    <= '0;
      blur_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        row_idx  <= '0;
        wr_ptr   <= '0;
        fill_cnt <= '0;
      end else begin
        if (state == LOAD) begin
          col_q  <= in_col;
          blur_q <= mode;
        end
        if ((state == VPASS || state == HPASS) && !last_row) row_idx <= row_idx + 1'b1;
        else row_idx <= '0;
        if (state == VPASS && last_row) begin
          wr_ptr <= (wr_ptr == PTR_W'(TAPS - 1)) ? '0 : wr_ptr + 1'b1;
          if (fill_cnt != FILL_W'(TAPS)) fill_cnt <= fill_cnt + 1'b1;
        end
      end
    end
  end

  // History contents need no reset; fill_cnt decides when they are used.
  always_ff @(posedge clk) begin
    if (state == VPASS) hist[wr_ptr][row_idx] <= vsum;
  end

  assign vtaps = col_q[row_idx*PIX_BITS +: TAPS*PIX_BITS];

  // After VPASS, wr_ptr points at the oldest column; tap j is j columns newer.
  always_comb begin
    logic [PW1-1:0] slot;
    slot  = '0;
    htaps = '0;
    for (int j = 0; j < TAPS; j++) begin
      slot = {1'b0, wr_ptr} + PW1'(j);
      if (slot >= PW1'(TAPS)) slot = slot - PW1'(TAPS);
      htaps[j*PIX_BITS +: PIX_BITS] = hist[slot[PTR_W-1:0]][row_idx];
    end
  end

  blur_tap_sum #(.PIX_BITS(PIX_BITS), .TAPS(TAPS)) u_vsum (
    .blur   (blur_q),
    .taps   (vtaps),
    .result (vsum)
  );

  blur_tap_sum #(.PIX_BITS(PIX_BITS), .TAPS(TAPS)) u_hsum (
    .blur   (blur_q),
    .taps   (htaps),
    .result (hsum)
  );

  assign busy      = (state != IDLE);
  assign out_valid = (state == HPASS);
  assign done      = (state == DONE);
  assign out_row   = out_valid ? row_idx : '0;
  assign out_pixel = out_valid ? hsum : '0;

endmodule

// File: tb/tb_sep_blur_engine.sv
// Self-checking bench for sep_blur_engine: directed table, corner sequences and
// random columns against a sliding-window reference model.
module tb_sep_blur_engine;

  localparam int PIX_BITS = 8;
  localparam int OUT_ROWS = 16;
  localparam int TAPS     = 5;
  localparam int COL_LEN  = OUT_ROWS + TAPS - 1;
  // Offsets (in edges after the start edge) at which done is first seen just
  // after the edge; an external sampler sees it at the following edge.
  localparam int FULL_OFF = 1 + 2*OUT_ROWS;
  localparam int FILL_OFF = 1 + OUT_ROWS;
  localparam int KW [TAPS] = '{1, 4, 6, 4, 1};
  localparam int KDIV = 16;

  logic clk = 1'b0;
  logic n_rst, start, mode, flush;
  logic [COL_LEN*PIX_BITS-1:0] in_col;
  logic busy, out_valid, done;
  logic [$clog2(OUT_ROWS)-1:0] out_row;
  logic [PIX_BITS-1:0] out_pixel;

  always #5 clk = ~clk;

  sep_blur_engine #(.PIX_BITS(PIX_BITS), .OUT_ROWS(OUT_ROWS), .TAPS(TAPS)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .mode      (mode),
    .flush     (flush),
    .in_col    (in_col),
    .busy      (busy),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_pixel (out_pixel),
    .done      (done)
  );

  typedef struct {
    int kind;
    bit m;
    int row;
    int pix;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cin [COL_LEN];
  int mh [TAPS][OUT_ROWS];
  int mcount = 0;
  int exp_pix [OUT_ROWS];
  bit exp_full;
  int got_pix [OUT_ROWS];
  int got_valid, got_done, done_off;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // kind 0: flat 100, 1: single 255 at row 10 of column 3, 2: 10*c+i, 3: random, 4: flat 20*c
  task automatic fill_col(input int kind, input int c);
    for (int i = 0; i < COL_LEN; i++) begin
      case (kind)
        0: cin[i] = 100;
        1: cin[i] = (c == 3 && i == 10) ? 255 : 0;
        2: cin[i] = 10*c + i;
        3: cin[i] = int'($urandom_range(0, 255));
        default: cin[i] = 20*c;
      endcase
    end
  endtask

  // Reference: keep the last TAPS vertical results as a sliding window.
  task automatic model_push(input bit m);
    int vc [OUT_ROWS];
    int s;
    for (int r = 0; r < OUT_ROWS; r++) begin
      if (m) begin
        s = 0;
        for (int j = 0; j < TAPS; j++) s += KW[j] * cin[r+j];
        vc[r] = (s + KDIV/2) / KDIV;
      end else begin
        vc[r] = cin[r + TAPS/2];
      end
    end
    if (mcount == TAPS) begin
      for (int i = 0; i < TAPS-1; i++) mh[i] = mh[i+1];
      mcount--;
    end
    mh[mcount] = vc;
    mcount++;
    exp_full = (mcount == TAPS);
    for (int r = 0; r < OUT_ROWS; r++) begin
      if (m) begin
        s = 0;
        for (int j = 0; j < TAPS; j++) s += KW[j] * mh[j][r];
        exp_pix[r] = (s + KDIV/2) / KDIV;
      end else begin
        exp_pix[r] = mh[TAPS/2][r];
      end
    end
  endtask

  task automatic drive_col();
    for (int i = 0; i < COL_LEN; i++) in_col[i*PIX_BITS +: PIX_BITS] = cin[i][PIX_BITS-1:0];
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    mcount = 0;
  endtask

  // One column; poke_off > 0 re-pulses start (with junk data) that many edges in.
  task automatic run_column(input bit m, input int poke_off);
    model_push(m);
    for (int r = 0; r < OUT_ROWS; r++) got_pix[r] = -1;
    @(negedge clk);
    drive_col();
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    got_valid = 0;
    got_done  = 0;
    done_off  = -1;
    for (int n = 1; n <= FULL_OFF + 4; n++) begin
      @(posedge clk);
      #1;
      start = (n == poke_off);
      if (n == poke_off) begin
        in_col = '1;
        mode   = ~m;
      end
      if (out_valid) begin
        if (exp_full && got_valid < OUT_ROWS) begin
          got_pix[got_valid] = int'(out_pixel);
          check("out_row", int'(out_row), got_valid);
          check($sformatf("pixel_row%0d", got_valid), int'(out_pixel), exp_pix[got_valid]);
        end
        got_valid++;
      end
      if (done) begin
        got_done++;
        if (done_off < 0) done_off = n;
      end
    end
    start = 1'b0;
    check("valid_count", got_valid, exp_full ? OUT_ROWS : 0);
    check("done_count", got_done, 1);
    check("done_offset", done_off, exp_full ? FULL_OFF : FILL_OFF);
    check("busy_after", int'(busy), 0);
  endtask

  // Start a column and stop at edge offset stop_n (inside HPASS when history is full).
  task automatic start_and_wait(input int stop_n);
    @(negedge clk);
    drive_col();
    mode  = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= stop_n; n++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    int last_kind;
    int cnt;

    vecs[0] = '{0, 1'b1, 0, 100};
    vecs[1] = '{0, 1'b1, 15, 100};
    vecs[2] = '{1, 1'b1, 8, 36};
    vecs[3] = '{1, 1'b1, 6, 6};
    vecs[4] = '{1, 1'b1, 0, 0};
    vecs[5] = '{2, 1'b0, 0, 32};
    vecs[6] = '{2, 1'b0, 7, 39};
    vecs[7] = '{2, 1'b0, 15, 47};

    n_rst = 1'b0; start = 1'b0; mode = 1'b0; flush = 1'b0; in_col = '0;
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_out_row", int'(out_row), 0);
    check("rst_out_pixel", int'(out_pixel), 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Directed five-column scenarios, checked at selected rows of the fifth output.
    last_kind = -1;
    for (int e = 0; e < 8; e++) begin
      if (vecs[e].kind != last_kind) begin
        do_flush();
        for (int c = 1; c <= TAPS; c++) begin
          fill_col(vecs[e].kind, c);
          run_column(vecs[e].m, 0);
        end
        last_kind = vecs[e].kind;
      end
      check($sformatf("table%0d_row%0d", e, vecs[e].row), got_pix[vecs[e].row], vecs[e].pix);
    end

    // Sixth column drops the first: window is columns 2..6 = 40,60,80,100,120.
    do_flush();
    for (int c = 1; c <= TAPS + 1; c++) begin
      fill_col(4, c);
      run_column(1'b1, 0);
    end
    check("wrap_row0", got_pix[0], 80);
    check("wrap_row15", got_pix[15], 80);

    // start pulsed during VPASS must be ignored.
    fill_col(3, 0);
    run_column(1'b1, 5);

    // flush during HPASS: no done, next start refills from empty.
    fill_col(3, 0);
    start_and_wait(20);
    check("pre_flush_valid", int'(out_valid), 1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_busy", int'(busy), 0);
    check("flush_out_valid", int'(out_valid), 0);
    @(negedge clk);
    flush = 1'b0;
    mcount = 0;
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (done || out_valid) cnt++;
    end
    check("flush_no_done", cnt, 0);
    fill_col(3, 0);
    run_column(1'b1, 0);

    // Refill, then reset in the middle of HPASS.
    for (int c = 0; c < TAPS - 1; c++) begin
      fill_col(3, c);
      run_column(1'(c % 2), 0);
    end
    fill_col(3, 0);
    start_and_wait(20);
    check("pre_reset_valid", int'(out_valid), 1);
    n_rst = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_done", int'(done), 0);
    @(negedge clk);
    n_rst = 1'b1;
    mcount = 0;
    fill_col(3, 0);
    run_column(1'b1, 0);

    // Random columns and modes, long enough to wrap the history several times.
    do_flush();
    for (int t = 0; t < 16; t++) begin
      fill_col(3, t);
      run_column(1'($urandom_range(0, 1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
